// File: rtl/csa.sv
// Registered carry-select adder: the low block ripples from cin, and each higher block
// precomputes sums for carry-in 0 and 1 and selects between them on the incoming carry.
module csa #(
  parameter int WIDTH = 4,
  parameter int BLOCK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  // Guard BLOCK first so the modulo below never divides by zero.
  localparam int BlkSafe = (BLOCK < 1) ? 1 : BLOCK;
  localparam int NumBlk  = WIDTH / BlkSafe;

  if (BLOCK < 1 || (WIDTH % BlkSafe) != 0 || WIDTH < 1) begin : g_param_check
    $error("csa: WIDTH must be a positive multiple of BLOCK, and BLOCK must be at least 1");
  end

  function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
    fa = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  // Ripple-carry chain of full adders; returns {carry_out, sum}.
  function automatic logic [BlkSafe:0] rca(input logic [BlkSafe-1:0] x,
                                           input logic [BlkSafe-1:0] y,
                                           input logic               ci);
    logic       c;
    logic [1:0] r;
    c = ci;
    for (int i = 0; i < BlkSafe; i++) begin
      r      = fa(x[i], y[i], c);
      rca[i] = r[0];
      c      = r[1];
    end
    rca[BlkSafe] = c;
  endfunction

  logic [WIDTH-1:0] sum;
  logic             carry;

  for (genvar g = 0; g < NumBlk; g++) begin : g_blk
    logic               co;
    logic [BlkSafe-1:0] ab;
    logic [BlkSafe-1:0] bb;

    assign ab = a[g*BlkSafe +: BlkSafe];
    assign bb = b[g*BlkSafe +: BlkSafe];

    if (g == 0) begin : g_rca
      logic [BlkSafe:0] r;
      assign r                       = rca(ab, bb, cin);
      assign sum[g*BlkSafe +: BlkSafe] = r[BlkSafe-1:0];
      assign co                      = r[BlkSafe];
    end else begin : g_sel
      logic [BlkSafe:0] r0;
      logic [BlkSafe:0] r1;
      logic             ci;
      assign ci                      = g_blk[g-1].co;
      assign r0                      = rca(ab, bb, 1'b0);
      assign r1                      = rca(ab, bb, 1'b1);
      assign sum[g*BlkSafe +: BlkSafe] = ci ? r1[BlkSafe-1:0] : r0[BlkSafe-1:0];
      assign co                      = ci ? r1[BlkSafe] : r0[BlkSafe];
    end
  end

  assign carry = g_blk[NumBlk-1].co;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s    <= '0;
      cout <= 1'b0;
    end else begin
      s    <= sum;
      cout <= carry;
    end
  end

endmodule

// File: tb/tb_csa.sv
// Directed and exhaustive checks of the registered 4-bit carry-select adder.
module tb_csa;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] s;
  logic       cout;

  int passed = 0;
  int total  = 0;

  csa #(
    .WIDTH(4),
    .BLOCK(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .cin (cin),
    .s   (s),
    .cout(cout)
  );

  always #5 clk = ~clk;

  // Drive operands, let one rising edge capture them, then sample 1 time unit later.
  task automatic step(input logic [3:0] av, input logic [3:0] bv, input logic cv);
    a   = av;
    b   = bv;
    cin = cv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a   = 4'hF;
    b   = 4'hF;
    cin = 1'b1;
    #1;
    total++;
    if ({cout, s} !== 5'b0_0000)
      $display("FAIL reset_before_edge: got cout=%b s=%b, want cout=0 s=0000", cout, s);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if ({cout, s} !== 5'b0_0000)
      $display("FAIL reset_held_edge: got cout=%b s=%b, want cout=0 s=0000", cout, s);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    // First edge after release captures the inputs still on the bus: F + F + 1 = 1F.
    @(posedge clk);
    #1;
    total++;
    if ({cout, s} !== 5'b1_1111)
      $display("FAIL reset_release_capture: got cout=%b s=%b, want cout=1 s=1111", cout, s);
    else passed++;
  endtask

  task automatic test_basic;
    logic [3:0] va [3] = '{4'b0000, 4'b0011, 4'b0111};
    logic [3:0] vb [3] = '{4'b0000, 4'b0101, 4'b0011};
    logic       vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [4:0] ve [3] = '{5'b0_0000, 5'b0_1000, 5'b0_1011};
    for (int i = 0; i < 3; i++) begin
      step(va[i], vb[i], vc[i]);
      total++;
      if ({cout, s} !== ve[i])
        $display("FAIL basic_%0d: got %b, want %b", i, {cout, s}, ve[i]);
      else passed++;
    end
  endtask

  task automatic test_wrap;
    step(4'b1111, 4'b1111, 1'b0);
    total++;
    if ({cout, s} !== 5'b1_1110)
      $display("FAIL wrap_cin0: got %b, want 11110", {cout, s});
    else passed++;
    step(4'b1111, 4'b1111, 1'b1);
    total++;
    if ({cout, s} !== 5'b1_1111)
      $display("FAIL wrap_cin1: got %b, want 11111", {cout, s});
    else passed++;
  endtask

  task automatic test_mux;
    step(4'b1010, 4'b1100, 1'b0);
    total++;
    if ({cout, s} !== 5'b1_0110)
      $display("FAIL mux_cin0: got %b, want 10110", {cout, s});
    else passed++;
    step(4'b1010, 4'b1100, 1'b1);
    total++;
    if ({cout, s} !== 5'b1_0111)
      $display("FAIL mux_cin1: got %b, want 10111", {cout, s});
    else passed++;
    // Low block carries out, selecting the carry-in-1 upper sum: 0110 + 0010 = 1000.
    step(4'b0110, 4'b0010, 1'b0);
    total++;
    if ({cout, s} !== 5'b0_1000)
      $display("FAIL mux_low_carry: got %b, want 01000", {cout, s});
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [3:0] va [5] = '{4'h1, 4'h8, 4'hC, 4'h5, 4'h9};
    logic [3:0] vb [5] = '{4'h2, 4'h8, 4'h3, 4'hA, 4'h6};
    logic       vc [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [4:0] ve [5] = '{5'h03, 5'h11, 5'h10, 5'h0F, 5'h10};
    for (int i = 0; i < 5; i++) begin
      step(va[i], vb[i], vc[i]);
      total++;
      if ({cout, s} !== ve[i])
        $display("FAIL back_to_back_%0d: got %h, want %h", i, {cout, s}, ve[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid;
    step(4'h7, 4'h6, 1'b0);
    total++;
    if ({cout, s} !== 5'h0D)
      $display("FAIL mid_pre: got %h, want 0d", {cout, s});
    else passed++;
    a   = 4'h9;
    b   = 4'h9;
    cin = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({cout, s} !== 5'h00)
      $display("FAIL mid_async_clear: got %h, want 00", {cout, s});
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if ({cout, s} !== 5'h00)
      $display("FAIL mid_discard: got %h, want 00", {cout, s});
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    step(4'h4, 4'hD, 1'b1);
    total++;
    if ({cout, s} !== 5'h12)
      $display("FAIL mid_resume: got %h, want 12", {cout, s});
    else passed++;
  endtask

  task automatic test_sweep;
    logic [8:0] v;
    logic [4:0] exp;
    for (int i = 0; i < 512; i++) begin
      v   = 9'(i);
      exp = 5'(v[7:4]) + 5'(v[3:0]) + 5'(v[8]);
      step(v[7:4], v[3:0], v[8]);
      total++;
      if ({cout, s} !== exp)
        $display("FAIL sweep a=%h b=%h cin=%b: got %h, want %h",
                 v[7:4], v[3:0], v[8], {cout, s}, exp);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_mux();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
